conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
Sequencer for the systolic-array convolution datapath. It loads a KxK weight set into the array, then produces each output pixel of a valid-mode convolution in turn. For each pixel it streams the KxK input taps from the input buffer, waits for the array pipeline to drain, and writes the result to the output buffer. It sits between the top-level START control and the array/memories, and exports its one-hot state for top-level debug.

Parameters:
K, 3, kernel size (KxK taps)
IMG_W, 4, input image width in pixels
IMG_H, 4, input image height in pixels
PIPE_LAT, 2, cycles from last accumulate to result valid at array output
ADDR_W, 8, width of all memory addresses

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  begin a convolution job; sampled only in IDLE
STATE  out  7  current one-hot state
NEXT_STATE  out  7  combinational next one-hot state
W_RE  out  1  weight memory read enable
W_ADDR  out  ADDR_W  weight memory address
W_LOAD  out  1  array weight load strobe (read data valid)
W_IDX  out  ADDR_W  tap index for W_LOAD
X_RE  out  1  input buffer read enable
X_ADDR  out  ADDR_W  input buffer address
ACC_EN  out  1  array accumulate strobe (input data valid)
ACC_CLR  out  1  clear accumulator; coincident with first ACC_EN of a pixel
TAP_IDX  out  ADDR_W  tap index accompanying ACC_EN
Y_WE  out  1  output buffer write enable
Y_ADDR  out  ADDR_W  output buffer address = oy*OW+ox
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle completion pulse

Behaviour:
- OW = IMG_W-K+1 and OH = IMG_H-K+1. Memories have synchronous read with 1-cycle latency.
- States, one-hot: IDLE=0000001, LOAD_W=0000010, COMPUTE=0000100, FLUSH=0001000, DRAIN=0010000, WRITE=0100000, DONE=1000000.
- Reset, asynchronous: STATE=IDLE. All counters 0. All strobes 0. All addresses 0. BUSY=0, DONE=0. Reset mid-job aborts immediately; no further writes occur.
- IDLE: if START=1 go to LOAD_W, else stay. START in any other state is ignored.
- LOAD_W: counter c runs 0..K*K, one step per cycle.
  - W_RE=1 with W_ADDR=c when c<K*K.
  - W_LOAD=1 with W_IDX=c-1 when c>=1.
  - At c=K*K go to COMPUTE with oy=ox=0. State lasts K*K+1 cycles.
- COMPUTE: tap counter t runs 0..K*K-1, with ky=t/K and kx=t%K maintained as separate counters.
  - X_RE=1, X_ADDR=(oy+ky)*IMG_W+(ox+kx).
  - At t=K*K-1 go to FLUSH.
- Accumulate strobes: ACC_EN is X_RE delayed 1 cycle. TAP_IDX is t delayed 1 cycle. ACC_CLR is (X_RE and t==0) delayed 1 cycle.
- FLUSH: 1 cycle; the last ACC_EN fires here. Then go to DRAIN.
- DRAIN: PIPE_LAT cycles, then go to WRITE. If PIPE_LAT=0, go straight to WRITE.
- WRITE: 1 cycle; Y_WE=1, Y_ADDR=oy*OW+ox.
  - Advance ox; wrap to 0 at OW-1 and increment oy.
  - If (oy,ox)=(OH-1,OW-1), go to DONE; else go to COMPUTE with t=0.
- DONE: DONE=1 for 1 cycle, then go to IDLE. A job can restart on the next START.
- Output timing: STATE, counters and strobes are registered. X_ADDR, W_ADDR, Y_ADDR and the enables derived from STATE may be decoded combinationally from registers, provided they are glitch-tolerant and valid throughout the cycle.
- Per pixel: K*K+1+PIPE_LAT+1 cycles. Job length from the first LOAD_W cycle: (K*K+1) + OH*OW*(K*K+2+PIPE_LAT) + 1 cycles.
- All address arithmetic is unsigned and truncated to ADDR_W. Parameters must keep every address below 2^ADDR_W.
- STATE is always exactly one-hot; NEXT_STATE is always one-hot.

Test Plan:
- Reset: drive RST_N=0 mid-COMPUTE → STATE=0000001 immediately (asynchronous), all strobes 0, no Y_WE afterwards; after release, START runs a clean job.
- Full job, defaults (K=3, 4x4, PIPE_LAT=2), START pulse:
  - LOAD_W for 10 cycles; W_ADDR 0..8; W_LOAD lags W_RE by 1.
  - 4 pixels of 13 cycles each.
  - DONE in cycle 63 counting the first LOAD_W cycle as 1; BUSY high in cycles 1–63.
- Address sequence, pixel (oy=1,ox=1): X_ADDR = 5,6,7,9,10,11,13,14,15; Y_ADDR=3. ACC_CLR coincides with the ACC_EN where TAP_IDX=0.
- Write ordering: exactly 4 Y_WE pulses with Y_ADDR 0,1,2,3. Each Y_WE occurs exactly PIPE_LAT+1 cycles after that pixel's last ACC_EN.
- START held high throughout: no restart until after DONE; the next job begins the cycle after returning to IDLE.
- Parameter sweep (K=1, PIPE_LAT=0, 3x3 image): 9 pixels of 3 cycles each; DONE at cycle 2+27+1=30.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_seq_ctrl
// Brief    : Weight-load and per-pixel tap sequencer for the systolic
//            convolution array (valid-mode output).
// Revision : 1.0 - initial release
// ============================================================================
module conv_seq_ctrl #(
    parameter int K        = 3,
    parameter int IMG_W    = 4,
    parameter int IMG_H    = 4,
    parameter int PIPE_LAT = 2,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [6:0]        state,
    output logic [6:0]        next_state,
    output logic              w_re,
    output logic [ADDR_W-1:0] w_addr,
    output logic              w_load,
    output logic [ADDR_W-1:0] w_idx,
    output logic              x_re,
    output logic [ADDR_W-1:0] x_addr,
    output logic              acc_en,
    output logic              acc_clr,
    output logic [ADDR_W-1:0] tap_idx,
    output logic              y_we,
    output logic [ADDR_W-1:0] y_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [6:0] {
        S_IDLE    = 7'b0000001,
        S_LOAD_W  = 7'b0000010,
        S_COMPUTE = 7'b0000100,
        S_FLUSH   = 7'b0001000,
        S_DRAIN   = 7'b0010000,
        S_WRITE   = 7'b0100000,
        S_DONE    = 7'b1000000
    } state_t;

    localparam logic [ADDR_W-1:0] c_kk     = ADDR_W'(K * K);
    localparam logic [ADDR_W-1:0] c_kk_m1  = ADDR_W'(K * K - 1);
    localparam logic [ADDR_W-1:0] c_k_m1   = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] c_img_w  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] c_ow     = ADDR_W'(IMG_W - K + 1);
    localparam logic [ADDR_W-1:0] c_ow_m1  = ADDR_W'(IMG_W - K);
    localparam logic [ADDR_W-1:0] c_oh_m1  = ADDR_W'(IMG_H - K);
    localparam logic [ADDR_W-1:0] c_lat_m1 = ADDR_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam logic [ADDR_W-1:0] c_one    = ADDR_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_c;
    logic [ADDR_W-1:0] r_t;
    logic [ADDR_W-1:0] r_ky;
    logic [ADDR_W-1:0] r_kx;
    logic [ADDR_W-1:0] r_oy;
    logic [ADDR_W-1:0] r_ox;
    logic [ADDR_W-1:0] r_d;
    logic              r_acc_en;
    logic              r_acc_clr;
    logic [ADDR_W-1:0] r_tap_idx;
    logic              w_last_pix;

    assign w_last_pix = (r_oy == c_oh_m1) && (r_ox == c_ow_m1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_LOAD_W;
            S_LOAD_W:  if (r_c == c_kk) w_next = S_COMPUTE;
            S_COMPUTE: if (r_t == c_kk_m1) w_next = S_FLUSH;
            S_FLUSH:   w_next = (PIPE_LAT == 0) ? S_WRITE : S_DRAIN;
            S_DRAIN:   if (r_d == c_lat_m1) w_next = S_WRITE;
            S_WRITE:   w_next = w_last_pix ? S_DONE : S_COMPUTE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_c       <= '0;
            r_t       <= '0;
            r_ky      <= '0;
            r_kx      <= '0;
            r_oy      <= '0;
            r_ox      <= '0;
            r_d       <= '0;
            r_acc_en  <= 1'b0;
            r_acc_clr <= 1'b0;
            r_tap_idx <= '0;
        end else begin
            r_state   <= w_next;
            // Array sees input-buffer data one cycle after the read request.
            r_acc_en  <= (r_state == S_COMPUTE);
            r_acc_clr <= (r_state == S_COMPUTE) && (r_t == '0);
            r_tap_idx <= r_t;
            case (r_state)
                S_IDLE: r_c <= '0;
                S_LOAD_W: begin
                    if (r_c == c_kk) begin
                        r_c  <= '0;
                        r_t  <= '0;
                        r_ky <= '0;
                        r_kx <= '0;
                        r_oy <= '0;
                        r_ox <= '0;
                    end else begin
                        r_c <= r_c + c_one;
                    end
                end
                S_COMPUTE: begin
                    if (r_t == c_kk_m1) begin
                        r_t  <= '0;
                        r_ky <= '0;
                        r_kx <= '0;
                    end else begin
                        r_t <= r_t + c_one;
                        if (r_kx == c_k_m1) begin
                            r_kx <= '0;
                            r_ky <= r_ky + c_one;
                        end else begin
                            r_kx <= r_kx + c_one;
                        end
                    end
                end
                S_FLUSH: r_d <= '0;
                S_DRAIN: r_d <= r_d + c_one;
                S_WRITE: begin
                    if (r_ox == c_ow_m1) begin
                        r_ox <= '0;
                        r_oy <= r_oy + c_one;
                    end else begin
                        r_ox <= r_ox + c_one;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address decodes are gated by state so idle/reset values stay at zero.
    assign w_re    = (r_state == S_LOAD_W) && (r_c < c_kk);
    assign w_addr  = w_re ? r_c : '0;
    assign w_load  = (r_state == S_LOAD_W) && (r_c != '0);
    assign w_idx   = w_load ? (r_c - c_one) : '0;
    assign x_re    = (r_state == S_COMPUTE);
    assign x_addr  = x_re ? ((r_oy + r_ky) * c_img_w + (r_ox + r_kx)) : '0;
    assign y_we    = (r_state == S_WRITE);
    assign y_addr  = y_we ? (r_oy * c_ow + r_ox) : '0;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign acc_en  = r_acc_en;
    assign acc_clr = r_acc_clr;
    assign tap_idx = r_tap_idx;
    assign state      = r_state;
    assign next_state = w_next;

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_seq_ctrl
// Brief    : Directed bench for conv_seq_ctrl (default build and K=1 sweep).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_seq_ctrl;

    localparam logic [6:0] c_idle    = 7'b0000001;
    localparam logic [6:0] c_load    = 7'b0000010;
    localparam logic [6:0] c_compute = 7'b0000100;
    localparam logic [6:0] c_flush   = 7'b0001000;
    localparam logic [6:0] c_drain   = 7'b0010000;
    localparam logic [6:0] c_write   = 7'b0100000;
    localparam logic [6:0] c_done    = 7'b1000000;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       start1;
    int         checks = 0;
    int         errors = 0;

    logic [6:0] state, next_state;
    logic       w_re, w_load, x_re, acc_en, acc_clr, y_we, busy, done;
    logic [7:0] w_addr, w_idx, x_addr, tap_idx, y_addr;

    logic [6:0] state1, next_state1;
    logic       w_re1, w_load1, x_re1, acc_en1, acc_clr1, y_we1, busy1, done1;
    logic [7:0] w_addr1, w_idx1, x_addr1, tap_idx1, y_addr1;

    conv_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .state(state), .next_state(next_state),
        .w_re(w_re), .w_addr(w_addr), .w_load(w_load), .w_idx(w_idx),
        .x_re(x_re), .x_addr(x_addr),
        .acc_en(acc_en), .acc_clr(acc_clr), .tap_idx(tap_idx),
        .y_we(y_we), .y_addr(y_addr), .busy(busy), .done(done)
    );

    conv_seq_ctrl #(.K(1), .IMG_W(3), .IMG_H(3), .PIPE_LAT(0), .ADDR_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .state(state1), .next_state(next_state1),
        .w_re(w_re1), .w_addr(w_addr1), .w_load(w_load1), .w_idx(w_idx1),
        .x_re(x_re1), .x_addr(x_addr1),
        .acc_en(acc_en1), .acc_clr(acc_clr1), .tap_idx(tap_idx1),
        .y_we(y_we1), .y_addr(y_addr1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle n of a default job, counting the first LOAD_W cycle as 1.
    function automatic logic [6:0] exp_state(input int n);
        int s;
        if (n >= 1 && n <= 10) return c_load;
        if (n >= 11 && n <= 62) begin
            s = (n - 11) % 13;
            if (s < 9)  return c_compute;
            if (s == 9) return c_flush;
            if (s < 12) return c_drain;
            return c_write;
        end
        if (n == 63) return c_done;
        return c_idle;
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== c_idle) begin
            errors++; $display("FAIL reset_state: got %b expected %b", state, c_idle);
        end
        checks++;
        if ({w_re, w_load, x_re, acc_en, acc_clr, y_we, busy, done} !== 8'h00) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00000000",
                               {w_re, w_load, x_re, acc_en, acc_clr, y_we, busy, done});
        end
        checks++;
        if ({w_addr, w_idx, x_addr, tap_idx, y_addr} !== 40'h0) begin
            errors++; $display("FAIL reset_addrs: got %h expected 0",
                               {w_addr, w_idx, x_addr, tap_idx, y_addr});
        end
        checks++;
        if (state1 !== c_idle) begin
            errors++; $display("FAIL reset_state_sweep: got %b expected %b", state1, c_idle);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one job cycle by cycle against the hand-derived schedule.
    task automatic run_job(input bit hold);
        int xt [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        int last_acc, nwe, m, p, s, c, ex, last_n;
        logic [6:0] es, en;
        logic [7:0] exp_strb, act_strb;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        last_acc = -100;
        nwe      = 0;
        last_n   = hold ? 65 : 64;
        for (int n = 1; n <= last_n; n++) begin
            m  = (n > 64) ? n - 64 : n;
            es = exp_state(m);
            en = (hold && m == 64) ? c_load : exp_state(m + 1);
            p = 0; s = 0; c = 0;
            exp_strb = 8'h00;
            if (m <= 10) begin
                c = m - 1;
                exp_strb[7] = (c < 9);
                exp_strb[6] = (c >= 1);
            end else if (m <= 62) begin
                p = (m - 11) / 13;
                s = (m - 11) % 13;
                exp_strb[5] = (s < 9);
                exp_strb[4] = (s >= 1 && s <= 9);
                exp_strb[3] = (s == 1);
                exp_strb[2] = (s == 12);
            end
            exp_strb[1] = (m <= 63);
            exp_strb[0] = (m == 63);
            act_strb = {w_re, w_load, x_re, acc_en, acc_clr, y_we, busy, done};

            checks++;
            if (state !== es) begin
                errors++; $display("FAIL job_state cyc %0d: got %b expected %b", n, state, es);
            end
            checks++;
            if (next_state !== en) begin
                errors++; $display("FAIL job_next_state cyc %0d: got %b expected %b", n, next_state, en);
            end
            checks++;
            if (act_strb !== exp_strb) begin
                errors++; $display("FAIL job_strobes cyc %0d: got %b expected %b", n, act_strb, exp_strb);
            end
            if (exp_strb[7]) begin
                checks++;
                if (w_addr !== 8'(c)) begin
                    errors++; $display("FAIL w_addr cyc %0d: got %0d expected %0d", n, w_addr, c);
                end
            end
            if (exp_strb[6]) begin
                checks++;
                if (w_idx !== 8'(c - 1)) begin
                    errors++; $display("FAIL w_idx cyc %0d: got %0d expected %0d", n, w_idx, c - 1);
                end
            end
            if (exp_strb[5]) begin
                ex = (p == 3) ? xt[s] : ((p / 2 + s / 3) * 4 + (p % 2) + (s % 3));
                checks++;
                if (x_addr !== 8'(ex)) begin
                    errors++; $display("FAIL x_addr cyc %0d: got %0d expected %0d", n, x_addr, ex);
                end
            end
            if (exp_strb[4]) begin
                checks++;
                if (tap_idx !== 8'(s - 1)) begin
                    errors++; $display("FAIL tap_idx cyc %0d: got %0d expected %0d", n, tap_idx, s - 1);
                end
            end
            if (exp_strb[2]) begin
                checks++;
                if (y_addr !== 8'(p)) begin
                    errors++; $display("FAIL y_addr cyc %0d: got %0d expected %0d", n, y_addr, p);
                end
            end
            if (y_we === 1'b1 && n <= 64) begin
                nwe++;
                checks++;
                if (n - last_acc !== 3) begin
                    errors++; $display("FAIL y_we_latency cyc %0d: got %0d expected 3", n, n - last_acc);
                end
            end
            if (acc_en === 1'b1) last_acc = n;
            @(negedge clk);
        end
        checks++;
        if (nwe !== 4) begin
            errors++; $display("FAIL y_we_count: got %0d expected 4", nwe);
        end
    endtask

    task automatic test_full_job();
        run_job(1'b0);
    endtask

    task automatic test_reset_midjob();
        int nwe;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        checks++;
        if (state !== c_compute) begin
            errors++; $display("FAIL midjob_pre_state: got %b expected %b", state, c_compute);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== c_idle) begin
            errors++; $display("FAIL midjob_async_state: got %b expected %b", state, c_idle);
        end
        checks++;
        if ({w_re, w_load, x_re, acc_en, acc_clr, y_we, busy, done} !== 8'h00) begin
            errors++; $display("FAIL midjob_async_strobes: got %b expected 00000000",
                               {w_re, w_load, x_re, acc_en, acc_clr, y_we, busy, done});
        end
        checks++;
        if ({x_addr, tap_idx} !== 16'h0) begin
            errors++; $display("FAIL midjob_async_addrs: got %h expected 0", {x_addr, tap_idx});
        end
        nwe = 0;
        repeat (3) begin
            @(negedge clk);
            if (y_we !== 1'b0) nwe++;
        end
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (y_we !== 1'b0) nwe++;
        end
        checks++;
        if (nwe !== 0) begin
            errors++; $display("FAIL midjob_no_write: got %0d writes expected 0", nwe);
        end
        checks++;
        if (state !== c_idle) begin
            errors++; $display("FAIL midjob_post_state: got %b expected %b", state, c_idle);
        end
        run_job(1'b0);
    endtask

    task automatic test_start_held();
        run_job(1'b1);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sweep();
        int p, s, nwe;
        logic [6:0] es;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        nwe = 0;
        for (int n = 1; n <= 31; n++) begin
            p = 0; s = 0;
            if (n <= 2) es = c_load;
            else if (n <= 29) begin
                p  = (n - 3) / 3;
                s  = (n - 3) % 3;
                es = (s == 0) ? c_compute : (s == 1) ? c_flush : c_write;
            end else if (n == 30) es = c_done;
            else es = c_idle;
            checks++;
            if (state1 !== es) begin
                errors++; $display("FAIL sweep_state cyc %0d: got %b expected %b", n, state1, es);
            end
            checks++;
            if (done1 !== (n == 30)) begin
                errors++; $display("FAIL sweep_done cyc %0d: got %b expected %b", n, done1, n == 30);
            end
            if (es == c_compute) begin
                checks++;
                if (x_addr1 !== 8'(p)) begin
                    errors++; $display("FAIL sweep_x_addr cyc %0d: got %0d expected %0d", n, x_addr1, p);
                end
            end
            if (es == c_write) begin
                checks++;
                if (y_addr1 !== 8'(p)) begin
                    errors++; $display("FAIL sweep_y_addr cyc %0d: got %0d expected %0d", n, y_addr1, p);
                end
            end
            if (y_we1 === 1'b1) nwe++;
            @(negedge clk);
        end
        checks++;
        if (nwe !== 9) begin
            errors++; $display("FAIL sweep_y_we_count: got %0d expected 9", nwe);
        end
    endtask

    initial begin
        test_reset();
        test_full_job();
        test_reset_midjob();
        test_start_held();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
